// File: rtl/mpsoc_ahb3_master_port.sv
// AHB3-Lite initiator: turns a command/response stream into pipelined SINGLE transfers.
// The address slot (A) drives the address phase and the data slot (D) tracks the data phase.
module mpsoc_ahb3_master_port #(
    parameter int         HADDR_SIZE = 32,
    parameter int         HDATA_SIZE = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [HDATA_SIZE-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_abort,

    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    output logic [HDATA_SIZE-1:0] HWDATA,

    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ERR,
        ST_ABORT
    } state_t;

    state_t state, next_state;

    logic                  a_valid;
    logic                  a_write;
    logic [HADDR_SIZE-1:0] a_addr;
    logic [2:0]            a_size;
    logic [HDATA_SIZE-1:0] a_wdata;
    logic                  d_valid;
    logic                  d_write;
    logic                  abort_pending;
    logic [3:0]            hprot_q;

    logic err_state;
    logic accept;
    logic move;
    logic complete;
    logic err_start;

    assign err_state = (state != ST_RUN);
    assign cmd_ready = HRESETn & ~err_state & (~a_valid | HREADY);
    assign accept    = cmd_valid & cmd_ready;
    assign move      = HREADY & a_valid;
    assign complete  = HREADY & d_valid;
    assign err_start = (state == ST_RUN) & d_valid & HRESP & ~HREADY;

    // The address phase is a direct view of slot A, so it holds whenever A is stalled.
    assign HSEL      = a_valid;
    assign HTRANS    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = a_size;
    assign HPROT     = hprot_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= ST_RUN;
        else          state <= next_state;
    end

    always_comb begin
        // NOTE: next_state gets its default before the case so no latch is inferred.
        next_state = state;
        case (state)
            ST_RUN:   if (err_start) next_state = ST_ERR;
            ST_ERR:   if (complete)  next_state = abort_pending ? ST_ABORT : ST_RUN;
            ST_ABORT: next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            a_valid       <= 1'b0;
            a_write       <= 1'b0;
            a_addr        <= '0;
            a_size        <= 3'b000;
            a_wdata       <= '0;
            d_valid       <= 1'b0;
            d_write       <= 1'b0;
            abort_pending <= 1'b0;
            hprot_q       <= 4'b0000;
            HWDATA        <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_abort     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let A->D, D->response and a new accept share one edge.
            hprot_q <= HPROT_VAL;

            if (err_start) begin
                // A command accepted on this very edge is cancelled along with any waiting one.
                a_valid       <= 1'b0;
                abort_pending <= a_valid | accept;
            end else if (accept) begin
                a_valid <= 1'b1;
                a_write <= cmd_write;
                a_addr  <= cmd_addr;
                a_size  <= cmd_size;
                a_wdata <= cmd_wdata;
            end else if (move) begin
                a_valid <= 1'b0;
            end

            if (move) begin
                d_valid <= 1'b1;
                d_write <= a_write;
                if (a_write) HWDATA <= a_wdata;
            end else if (complete) begin
                d_valid <= 1'b0;
            end

            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_abort <= 1'b0;
            if (complete) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= d_write ? '0 : HRDATA;
                rsp_err   <= HRESP;
            end else if (state == ST_ABORT) begin
                rsp_valid     <= 1'b1;
                rsp_err       <= 1'b1;
                rsp_abort     <= 1'b1;
                abort_pending <= 1'b0;
            end
        end
    end

endmodule
